// File: rtl/mtm_alu_rx_deserializer_if.sv
// Link-side bundle of the ALU serial receiver: serial line in, decoded packet out.
// master = the deserializer that drives the packet fields, slave = the consumer feeding sin.
interface mtm_alu_rx_deserializer_if;
  logic        sin;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  OP;
  logic        data_valid;
  logic [5:0]  err_flags;
  logic        err_valid;

  modport master (
    input  sin,
    output A, B, OP, data_valid, err_flags, err_valid
  );

  modport slave (
    output sin,
    input  A, B, OP, data_valid, err_flags, err_valid
  );
endinterface

// File: rtl/mtm_alu_rx_deserializer.sv
// Serial packet receiver for the ALU link: 8 data frames + 1 command frame, checked for count/CRC/opcode.
// Optional idle timeout on partial packets is enabled by defining MTM_ALU_RX_TIMEOUT_EN.
module mtm_alu_rx_deserializer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  mtm_alu_rx_deserializer_if.master        bus
);

`ifdef MTM_ALU_RX_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ERR_DATA = 3'b100;
  localparam logic [2:0] ERR_CRC  = 3'b010;
  localparam logic [2:0] ERR_OP   = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TYPE,
    S_DATA,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic                is_cmd_q, is_cmd_d;
  logic [7:0]          shift_q, shift_d;
  logic [63:0]         data_q, data_d;
  logic [3:0]          frame_cnt_q, frame_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [2:0]          op_q, op_d;
  logic [2:0]          err_q, err_d;
  logic                data_valid_q, data_valid_d;
  logic                err_valid_q, err_valid_d;

  // CRC4, poly x^4+x+1, init 0, bits consumed MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] bits);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ bits[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
  endfunction

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    is_cmd_d     = is_cmd_q;
    shift_d      = shift_q;
    data_d       = data_q;
    frame_cnt_d  = frame_cnt_q;
    idle_cnt_d   = '0;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    err_d        = err_q;
    data_valid_d = 1'b0;
    err_valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus.sin) begin
          state_d = S_TYPE;
        end else if (TIMEOUT_EN && (frame_cnt_q != 4'd0)) begin
          // A stalled partial packet is dropped without reporting anything.
          if (idle_cnt_q == IDLE_LAST) begin
            frame_cnt_d = 4'd0;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
      end
      S_TYPE: begin
        is_cmd_d  = bus.sin;
        bit_cnt_d = 3'd7;
        state_d   = S_DATA;
      end
      S_DATA: begin
        shift_d = {shift_q[6:0], bus.sin};
        if (bit_cnt_q == 3'd0) begin
          state_d = S_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      S_STOP: begin
        state_d = S_IDLE;
        if (!bus.sin) begin
          err_valid_d = 1'b1;
          err_d       = ERR_DATA;
          frame_cnt_d = 4'd0;
        end else if (!is_cmd_q) begin
          // Bytes shift in as B[31:24] first, so data_q ends up as {B, A}.
          if (frame_cnt_q < 4'd8) data_d = {data_q[55:0], shift_q};
          if (frame_cnt_q < 4'd9) frame_cnt_d = frame_cnt_q + 4'd1;
        end else begin
          frame_cnt_d = 4'd0;
          if (frame_cnt_q != 4'd8) begin
            err_valid_d = 1'b1;
            err_d       = ERR_DATA;
          end else if (crc4({data_q, 1'b1, shift_q[6:4]}) != shift_q[3:0]) begin
            err_valid_d = 1'b1;
            err_d       = ERR_CRC;
          end else if (!op_legal(shift_q[6:4])) begin
            err_valid_d = 1'b1;
            err_d       = ERR_OP;
          end else begin
            data_valid_d = 1'b1;
            b_d          = data_q[63:32];
            a_d          = data_q[31:0];
            op_d         = shift_q[6:4];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      is_cmd_q     <= 1'b0;
      shift_q      <= 8'h00;
      data_q       <= 64'h0;
      frame_cnt_q  <= 4'd0;
      idle_cnt_q   <= '0;
      a_q          <= 32'h0;
      b_q          <= 32'h0;
      op_q         <= 3'b000;
      err_q        <= 3'b000;
      data_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      is_cmd_q     <= is_cmd_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      frame_cnt_q  <= frame_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      err_q        <= err_d;
      data_valid_q <= data_valid_d;
      err_valid_q  <= err_valid_d;
    end
  end

  assign bus.A          = a_q;
  assign bus.B          = b_q;
  assign bus.OP         = op_q;
  assign bus.data_valid = data_valid_q;
  assign bus.err_valid  = err_valid_q;

  // The serializer expects the error kind twice in the 6-bit vector.
  for (genvar gi = 0; gi < 2; gi++) begin : g_err_dup
    assign bus.err_flags[gi*3 +: 3] = err_q;
  end

endmodule

// File: tb/tb_mtm_alu_rx_deserializer.sv
// Directed bench for mtm_alu_rx_deserializer: frame-level model plus per-cycle output compare.
// Honours MTM_ALU_RX_TIMEOUT_EN for the stalled-packet scenario.
module tb_mtm_alu_rx_deserializer;

  localparam int TIMEOUT = 64;
`ifdef MTM_ALU_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   cyc = 0;

  mtm_alu_rx_deserializer_if bus();

  mtm_alu_rx_deserializer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state (written only by the stimulus process) ----------------
  int          m_cnt;
  logic [7:0]  m_bytes [8];
  logic [31:0] exp_A, exp_B;
  logic [2:0]  exp_OP;
  logic [5:0]  exp_flags;
  int          pulse_cyc = -1;
  bit          pulse_dv, pulse_ev;
  bit          chk_en = 1'b0;
  int          lit_cyc = -1;
  int          lit_kind = 0;

  // ---------------- checker state (written only by the compare process) ----------------
  int   checks = 0;
  int   errors = 0;
  int   last_dv = -1000;
  logic exp_dv, exp_ev;

  // Remainder of {B,A,1,OP} * x^4 modulo x^4+x+1, by long division.
  function automatic logic [3:0] model_crc(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    end
    return m[3:0];
  endfunction

  task automatic model_reset();
    m_cnt     = 0;
    exp_A     = 32'h0;
    exp_B     = 32'h0;
    exp_OP    = 3'b000;
    exp_flags = 6'b000000;
    pulse_dv  = 1'b0;
    pulse_ev  = 1'b0;
  endtask

  task automatic post_err(input logic [2:0] kind);
    exp_flags = {kind, kind};
    pulse_cyc = cyc;
    pulse_dv  = 1'b0;
    pulse_ev  = 1'b1;
  endtask

  // Called right after the edge that sampled the stop bit.
  task automatic model_frame(input logic is_cmd, input logic [7:0] byt, input logic stop_bit);
    logic [63:0] ba;
    logic [2:0]  op;
    if (!stop_bit) begin
      post_err(3'b100);
      m_cnt = 0;
    end else if (!is_cmd) begin
      if (m_cnt < 8) m_bytes[m_cnt] = byt;
      if (m_cnt < 9) m_cnt++;
    end else begin
      ba = 64'h0;
      for (int k = 0; k < 8; k++) ba[63-8*k -: 8] = m_bytes[k];
      op = byt[6:4];
      if (m_cnt != 8) post_err(3'b100);
      else if (model_crc(ba[63:32], ba[31:0], op) != byt[3:0]) post_err(3'b010);
      else if (op[1]) post_err(3'b001);
      else begin
        exp_B     = ba[63:32];
        exp_A     = ba[31:0];
        exp_OP    = op;
        pulse_cyc = cyc;
        pulse_dv  = 1'b1;
        pulse_ev  = 1'b0;
      end
      m_cnt = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_frame(input logic is_cmd, input logic [7:0] byt, input logic stop_bit);
    logic [10:0] bits;
    bits = {1'b0, is_cmd, byt, stop_bit};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      bus.sin = bits[i];
    end
    @(posedge clk);
    #1;
    model_frame(is_cmd, byt, stop_bit);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sin = 1'b1;
    end
    if (TO_EN && n >= TIMEOUT && m_cnt != 0) m_cnt = 0;
  endtask

  task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                             input logic [3:0] crc_flip, input int nbytes, input int gap);
    logic [63:0] ba;
    ba = {b, a};
    for (int k = 0; k < nbytes; k++) begin
      send_frame(1'b0, (k < 8) ? ba[63-8*k -: 8] : 8'hA5, 1'b1);
      if (gap > 0) idle(gap);
    end
    send_frame(1'b1, {1'b0, op, model_crc(b, a, op) ^ crc_flip}, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.sin = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk_en   = 1'b1;
    lit_cyc  = cyc;
    lit_kind = 5;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pin(input int kind);
    lit_cyc  = cyc;
    lit_kind = kind;
  endtask

  // ---------------- compare process ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_dv = (cyc == pulse_cyc) && pulse_dv;
      exp_ev = (cyc == pulse_cyc) && pulse_ev;
      chk("data_valid", bus.data_valid, exp_dv);
      chk("err_valid", bus.err_valid, exp_ev);
      chk("A", bus.A, exp_A);
      chk("B", bus.B, exp_B);
      chk("OP", bus.OP, exp_OP);
      chk("err_flags", bus.err_flags, exp_flags);
      if (cyc == lit_cyc) begin
        case (lit_kind)
          1: begin
            chk("lit_crc_model", model_crc(32'h3, 32'h5, 3'b100), 4'hC);
            chk("lit_add_dv", bus.data_valid, 1'b1);
            chk("lit_add_A", bus.A, 32'h5);
            chk("lit_add_B", bus.B, 32'h3);
            chk("lit_add_OP", bus.OP, 3'b100);
            chk("lit_add_ev", bus.err_valid, 1'b0);
          end
          2: begin
            chk("lit_crc_ev", bus.err_valid, 1'b1);
            chk("lit_crc_flags", bus.err_flags, 6'b010010);
            chk("lit_crc_A_held", bus.A, 32'h5);
          end
          3: begin
            chk("lit_op_ev", bus.err_valid, 1'b1);
            chk("lit_op_flags", bus.err_flags, 6'b001001);
          end
          4: begin
            chk("lit_cnt_ev", bus.err_valid, 1'b1);
            chk("lit_cnt_flags", bus.err_flags, 6'b100100);
            chk("lit_cnt_dv", bus.data_valid, 1'b0);
          end
          5: begin
            chk("lit_rst_outs", {bus.A, bus.B, bus.OP, bus.err_flags, bus.data_valid, bus.err_valid}, 75'h0);
          end
          6: begin
            chk("lit_b2b_dv", bus.data_valid, 1'b1);
            chk("lit_b2b_gap", cyc - last_dv, 99);
          end
          7: begin
            if (TO_EN) begin
              chk("lit_to_dv", bus.data_valid, 1'b1);
              chk("lit_to_A", bus.A, 32'h11);
              chk("lit_to_B", bus.B, 32'hCAFEF00D);
            end else begin
              chk("lit_to_ev", bus.err_valid, 1'b1);
              chk("lit_to_flags", bus.err_flags, 6'b100100);
            end
          end
          default: ;
        endcase
      end
      if (bus.data_valid) begin
        $display("cycle %0d: data_valid A=%08h B=%08h OP=%03b", cyc, bus.A, bus.B, bus.OP);
        last_dv = cyc;
      end
      if (bus.err_valid) $display("cycle %0d: err_valid err_flags=%06b", cyc, bus.err_flags);
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    bus.sin = 1'b1;
    rst_n   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    idle(3);

    send_packet(32'h3, 32'h5, 3'b100, 4'h0, 8, 0);  pin(1); idle(3);
    send_packet(32'h3, 32'h5, 3'b100, 4'h1, 8, 2);  pin(2); idle(2);
    send_packet(32'h3, 32'h5, 3'b010, 4'h0, 8, 0);  pin(3); idle(2);
    send_packet(32'h3, 32'h5, 3'b001, 4'h0, 7, 0);  pin(4); idle(2);
    send_packet(32'h3, 32'h5, 3'b001, 4'h0, 9, 1);  pin(4); idle(2);

    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    send_frame(1'b0, 8'h33, 1'b0);                   pin(4); idle(2);
    send_packet(32'h12345678, 32'h9ABCDEF0, 3'b001, 4'h0, 8, 0); idle(3);

    send_frame(1'b0, 8'h44, 1'b1);
    send_frame(1'b0, 8'h55, 1'b1);
    send_frame(1'b0, 8'h66, 1'b1);
    @(negedge clk); bus.sin = 1'b0;
    @(negedge clk); bus.sin = 1'b0;
    @(negedge clk); bus.sin = 1'b1;
    @(negedge clk); bus.sin = 1'b0;
    do_reset();
    idle(2);
    send_packet(32'hFFFFFFFF, 32'h0F0F0F0F, 3'b000, 4'h0, 8, 0); idle(4);

    send_packet(32'h00000100, 32'h00000001, 3'b101, 4'h0, 8, 0);
    send_packet(32'h00000007, 32'h00000008, 3'b100, 4'h0, 8, 0); pin(6); idle(3);

    for (int k = 0; k < 4; k++) send_frame(1'b0, 8'h77, 1'b1);
    idle(70);
    send_packet(32'hCAFEF00D, 32'h00000011, 3'b001, 4'h0, 8, 0); pin(7);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
